// File: rtl/riscv_core_pkg.sv
// Shared defaults and types for the riscv_core fetch path.
// Default widths, reset PC and the {pc, instr} fetch queue entry layout.
package riscv_core_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int ILEN_DEFAULT = 32;
  localparam logic [XLEN_DEFAULT-1:0] RESET_PC_DEFAULT = '0;

  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] pc;
    logic [ILEN_DEFAULT-1:0] instr;
  } if_entry_t;

endpackage

// File: rtl/riscv_core_sync_fifo.sv
// Synchronous FIFO with registered storage and an asynchronous head read.
// Power-of-two DEPTH; a separate count distinguishes full from empty.
module riscv_core_sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     srst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clr,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW:0]      count_reg;

  // Storage carries no reset; stale words are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (srst || clr) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign dout  = mem[rd_ptr_reg];
  assign full  = (count_reg == (AW+1)'(DEPTH));
  assign empty = (count_reg == '0);
  assign count = count_reg;

endmodule

// File: rtl/riscv_core_if_fetch_queue.sv
// IF->ID boundary: fetch PC register feeding a DEPTH-entry {pc, instr} queue
// with valid/ready handshake, stall buffering and flush/redirect.
module riscv_core_if_fetch_queue
  import riscv_core_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter int              ILEN     = ILEN_DEFAULT,
  parameter int              DEPTH    = 2,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     ACT,
  input  logic [XLEN-1:0]          s_if_pcin_Q,
  input  logic                     s_id_clear_Q,
  input  logic                     s_id_stall_Q,
  input  logic                     fetch_valid,
  input  logic [ILEN-1:0]          fetch_instr,
  output logic [XLEN-1:0]          r_pc_Q,
  output logic                     fetch_ready,
  output logic                     id_valid,
  output logic [XLEN-1:0]          id_pc,
  output logic [ILEN-1:0]          id_instr,
  output logic                     id_clear,
  output logic [$clog2(DEPTH):0]   occupancy
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } entry_t;

  logic            flush;
  logic            deq;
  logic            enq;
  logic            full;
  logic            empty;
  entry_t          wr_entry;
  entry_t          head_entry;
  logic [XLEN-1:0] r_pc_reg;
  logic            id_clear_reg;

  assign flush       = s_id_clear_Q;
  assign deq         = id_valid && !s_id_stall_Q;
  assign fetch_ready = !full || deq;
  assign enq         = ACT && fetch_valid && fetch_ready && !flush;

  assign wr_entry.pc    = r_pc_reg;
  assign wr_entry.instr = fetch_instr;

  riscv_core_sync_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .srst  (RST),
    .push  (enq),
    .pop   (deq && !flush),
    .clr   (flush),
    .din   (wr_entry),
    .dout  (head_entry),
    .full  (full),
    .empty (empty),
    .count (occupancy)
  );

  // The PC only advances when the fetch at r_pc was accepted, or on a redirect.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_pc_reg     <= RESET_PC;
      id_clear_reg <= 1'b0;
    end else begin
      id_clear_reg <= flush;
      if ((flush && ACT) || enq) begin
        r_pc_reg <= s_if_pcin_Q;
      end
    end
  end

  assign r_pc_Q   = r_pc_reg;
  assign id_clear = id_clear_reg;
  assign id_valid = !empty;
  assign id_pc    = id_valid ? head_entry.pc    : '0;
  assign id_instr = id_valid ? head_entry.instr : '0;

endmodule

// File: tb/tb_riscv_core_if_fetch_queue.sv
// Directed bench for riscv_core_if_fetch_queue (DEPTH=2, RESET_PC=0).
// Instruction memory model: instr = pc ^ 32'hDEAD0000.
module tb_riscv_core_if_fetch_queue;

  localparam logic [31:0] IMASK = 32'hDEAD_0000;

  logic        CLK = 1'b0;
  logic        RST, ACT, s_id_clear_Q, s_id_stall_Q, fetch_valid;
  logic [31:0] s_if_pcin_Q, fetch_instr, r_pc_Q, id_pc, id_instr;
  logic        fetch_ready, id_valid, id_clear;
  logic [1:0]  occupancy;
  logic        pc_follow;
  logic [31:0] pc_force;
  int          checks = 0;
  int          errors = 0;

  always #5 CLK = ~CLK;

  assign s_if_pcin_Q = pc_follow ? r_pc_Q + 32'd4 : pc_force;
  assign fetch_instr = r_pc_Q ^ IMASK;

  riscv_core_if_fetch_queue #(
    .XLEN(32), .ILEN(32), .DEPTH(2), .RESET_PC(32'h0)
  ) dut (
    .CLK(CLK), .RST(RST), .ACT(ACT), .s_if_pcin_Q(s_if_pcin_Q),
    .s_id_clear_Q(s_id_clear_Q), .s_id_stall_Q(s_id_stall_Q),
    .fetch_valid(fetch_valid), .fetch_instr(fetch_instr), .r_pc_Q(r_pc_Q),
    .fetch_ready(fetch_ready), .id_valid(id_valid), .id_pc(id_pc),
    .id_instr(id_instr), .id_clear(id_clear), .occupancy(occupancy)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1; ACT = 0; s_id_clear_Q = 0; s_id_stall_Q = 0; fetch_valid = 0;
    pc_follow = 0; pc_force = 32'h0;
    step(); step();
    checks++; if (r_pc_Q !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp %h", r_pc_Q, 32'h0); end
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL reset_id_valid got %b exp 0", id_valid); end
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL reset_occ got %0d exp 0", occupancy); end
    checks++; if (fetch_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", fetch_ready); end
    checks++; if (id_clear !== 1'b0) begin errors++; $display("FAIL reset_id_clear got %b exp 0", id_clear); end
    checks++; if (id_pc !== 32'h0) begin errors++; $display("FAIL reset_id_pc got %h exp 0", id_pc); end
    $display("reset: r_pc=%h occ=%0d ready=%b", r_pc_Q, occupancy, fetch_ready);
    RST = 0;
  endtask

  task automatic test_streaming();
    logic [31:0] exp_pc;
    ACT = 1; s_id_clear_Q = 1; pc_force = 32'h100;
    step();
    checks++; if (r_pc_Q !== 32'h100) begin errors++; $display("FAIL redirect_pc got %h exp 100", r_pc_Q); end
    checks++; if (id_clear !== 1'b1) begin errors++; $display("FAIL redirect_id_clear got %b exp 1", id_clear); end
    s_id_clear_Q = 0; fetch_valid = 1; pc_follow = 1;
    for (int i = 0; i < 3; i++) begin
      exp_pc = 32'h100 + 32'(4 * i);
      step();
      checks++; if (id_pc !== exp_pc) begin errors++; $display("FAIL stream_id_pc got %h exp %h", id_pc, exp_pc); end
      checks++; if (id_instr !== (exp_pc ^ IMASK)) begin errors++; $display("FAIL stream_id_instr got %h exp %h", id_instr, exp_pc ^ IMASK); end
      checks++; if (occupancy !== 2'd1) begin errors++; $display("FAIL stream_occ got %0d exp 1", occupancy); end
      $display("stream: id_pc=%h occ=%0d", id_pc, occupancy);
    end
  endtask

  task automatic test_fill();
    fetch_valid = 0; pc_follow = 0; pc_force = 32'h200; s_id_clear_Q = 1;
    step();
    checks++; if (occupancy !== 2'd0 || r_pc_Q !== 32'h200) begin errors++; $display("FAIL fill_setup got occ=%0d pc=%h exp occ=0 pc=200", occupancy, r_pc_Q); end
    s_id_clear_Q = 0; s_id_stall_Q = 1; fetch_valid = 1; pc_follow = 1;
    step(); step();
    checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL fill_occ got %0d exp 2", occupancy); end
    checks++; if (fetch_ready !== 1'b0) begin errors++; $display("FAIL fill_ready got %b exp 0", fetch_ready); end
    checks++; if (r_pc_Q !== 32'h208) begin errors++; $display("FAIL fill_pc got %h exp 208", r_pc_Q); end
    step();
    checks++; if (r_pc_Q !== 32'h208 || id_pc !== 32'h200) begin errors++; $display("FAIL fill_hold got pc=%h id_pc=%h exp 208/200", r_pc_Q, id_pc); end
    $display("fill: occ=%0d ready=%b r_pc=%h", occupancy, fetch_ready, r_pc_Q);
    fetch_valid = 0; s_id_stall_Q = 0;
    step();
    checks++; if (id_pc !== 32'h204 || occupancy !== 2'd1) begin errors++; $display("FAIL drain1 got id_pc=%h occ=%0d exp 204/1", id_pc, occupancy); end
    step();
    checks++; if (id_valid !== 1'b0 || id_pc !== 32'h0) begin errors++; $display("FAIL drain2 got valid=%b id_pc=%h exp 0/0", id_valid, id_pc); end
    $display("drain: id_valid=%b occ=%0d", id_valid, occupancy);
  endtask

  task automatic test_full_enq_deq();
    s_id_stall_Q = 1; fetch_valid = 1;
    step(); step();
    checks++; if (occupancy !== 2'd2 || r_pc_Q !== 32'h210) begin errors++; $display("FAIL full_setup got occ=%0d pc=%h exp 2/210", occupancy, r_pc_Q); end
    s_id_stall_Q = 0;
    #1;
    checks++; if (fetch_ready !== 1'b1) begin errors++; $display("FAIL full_deq_ready got %b exp 1", fetch_ready); end
    step();
    checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL full_swap_occ got %0d exp 2", occupancy); end
    checks++; if (id_pc !== 32'h20C || r_pc_Q !== 32'h214) begin errors++; $display("FAIL full_swap got id_pc=%h pc=%h exp 20c/214", id_pc, r_pc_Q); end
    step();
    checks++; if (id_pc !== 32'h210 || id_instr !== (32'h210 ^ IMASK)) begin errors++; $display("FAIL full_written got id_pc=%h instr=%h exp 210/%h", id_pc, id_instr, 32'h210 ^ IMASK); end
    $display("full_swap: occ=%0d id_pc=%h r_pc=%h", occupancy, id_pc, r_pc_Q);
  endtask

  task automatic test_flush();
    checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL flush_setup got occ=%0d exp 2", occupancy); end
    s_id_clear_Q = 1; pc_follow = 0; pc_force = 32'h400;
    step();
    checks++; if (id_valid !== 1'b0 || occupancy !== 2'd0) begin errors++; $display("FAIL flush_empty got valid=%b occ=%0d exp 0/0", id_valid, occupancy); end
    checks++; if (id_clear !== 1'b1) begin errors++; $display("FAIL flush_id_clear got %b exp 1", id_clear); end
    checks++; if (r_pc_Q !== 32'h400) begin errors++; $display("FAIL flush_pc got %h exp 400", r_pc_Q); end
    s_id_clear_Q = 0; pc_follow = 1;
    step();
    checks++; if (id_pc !== 32'h400 || id_clear !== 1'b0) begin errors++; $display("FAIL flush_refetch got id_pc=%h clr=%b exp 400/0", id_pc, id_clear); end
    $display("flush: id_pc=%h r_pc=%h", id_pc, r_pc_Q);
    ACT = 0; s_id_clear_Q = 1; pc_follow = 0; pc_force = 32'h500;
    step();
    checks++; if (occupancy !== 2'd0 || r_pc_Q !== 32'h404) begin errors++; $display("FAIL flush_inact got occ=%0d pc=%h exp 0/404", occupancy, r_pc_Q); end
    s_id_clear_Q = 0;
    step();
    checks++; if (occupancy !== 2'd0 || r_pc_Q !== 32'h404) begin errors++; $display("FAIL inact_noenq got occ=%0d pc=%h exp 0/404", occupancy, r_pc_Q); end
    $display("flush_inactive: occ=%0d r_pc=%h", occupancy, r_pc_Q);
  endtask

  task automatic test_reset_midstream();
    ACT = 1; s_id_stall_Q = 1; fetch_valid = 1; pc_follow = 1;
    step(); step();
    checks++; if (occupancy !== 2'd2 || r_pc_Q !== 32'h40C) begin errors++; $display("FAIL mid_setup got occ=%0d pc=%h exp 2/40c", occupancy, r_pc_Q); end
    RST = 1; s_id_clear_Q = 1; pc_follow = 0; pc_force = 32'h600;
    step();
    checks++; if (r_pc_Q !== 32'h0) begin errors++; $display("FAIL mid_reset_pc got %h exp 0", r_pc_Q); end
    checks++; if (occupancy !== 2'd0 || id_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_q got occ=%0d valid=%b exp 0/0", occupancy, id_valid); end
    checks++; if (id_clear !== 1'b0) begin errors++; $display("FAIL mid_reset_clr got %b exp 0", id_clear); end
    $display("reset_mid: r_pc=%h occ=%0d id_clear=%b", r_pc_Q, occupancy, id_clear);
    RST = 0; s_id_clear_Q = 0; fetch_valid = 0;
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_fill();
    test_full_enq_deq();
    test_flush();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
